// File: rtl/coreriscv_axi4_finish_ingress_queue.sv
// coreriscv_axi4_finish_ingress_queue: per-client finish-message FIFO that stamps the source ID and drops illegal destinations
module coreriscv_axi4_finish_ingress_queue #(
  parameter int SRC_ID  = 0,
  parameter int DEPTH   = 2,
  parameter int NUM_DST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       io_enq_ready,
  input  logic                       io_enq_valid,
  input  logic [1:0]                 io_enq_bits_header_dst,
  input  logic [1:0]                 io_enq_bits_payload_manager_xact_id,
  input  logic                       io_deq_ready,
  output logic                       io_deq_valid,
  output logic [1:0]                 io_deq_bits_header_src,
  output logic [1:0]                 io_deq_bits_header_dst,
  output logic [1:0]                 io_deq_bits_payload_manager_xact_id,
  output logic [$clog2(DEPTH):0]     io_count,
  output logic                       io_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          drop_q, drop_d;
  logic          legal, enq_fire, deq_fire, push;
  assign legal        = int'(io_enq_bits_header_dst) < NUM_DST;
  assign io_enq_ready = count_q != FULL;
  assign io_deq_valid = count_q != '0;
  assign enq_fire     = io_enq_valid & io_enq_ready;
  assign deq_fire     = io_deq_valid & io_deq_ready;
  assign push         = enq_fire & legal;
  assign io_count     = count_q;
  assign io_drop      = drop_q;
  assign io_deq_bits_header_src              = 2'(SRC_ID);
  assign io_deq_bits_header_dst              = mem_q[rd_ptr_q][3:2];
  assign io_deq_bits_payload_manager_xact_id = mem_q[rd_ptr_q][1:0];
  // full/empty come from count alone, so pointers simply wrap
  always_comb begin
    rd_ptr_d = deq_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, deq_fire};
    drop_d   = enq_fire & ~legal;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {io_enq_bits_header_dst, io_enq_bits_payload_manager_xact_id};
  end
endmodule

// File: tb/tb_coreriscv_axi4_finish_ingress_queue.sv
// tb_coreriscv_axi4_finish_ingress_queue: directed vector table, async reset sequence and randomized model comparison
module tb_coreriscv_axi4_finish_ingress_queue;
  localparam int DEPTH = 2, NUM_DST = 3, SRC_ID = 2;
  typedef struct {
    logic       ev;
    logic [1:0] dst, x;
    logic       dr;
    logic       rdy, vld;
    logic [1:0] edst, ex;
    logic [1:0] cnt;
    logic       drop;
  } row_t;
  logic clk = 1'b0, reset = 1'b0;
  logic enq_valid = 1'b0, deq_ready = 1'b0;
  logic [1:0] enq_dst = '0, enq_x = '0;
  logic enq_ready, deq_valid, drop;
  logic [1:0] deq_src, deq_dst, deq_x, count;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  coreriscv_axi4_finish_ingress_queue #(.SRC_ID(SRC_ID), .DEPTH(DEPTH), .NUM_DST(NUM_DST)) dut (
    .clk(clk), .reset(reset),
    .io_enq_ready(enq_ready), .io_enq_valid(enq_valid),
    .io_enq_bits_header_dst(enq_dst), .io_enq_bits_payload_manager_xact_id(enq_x),
    .io_deq_ready(deq_ready), .io_deq_valid(deq_valid),
    .io_deq_bits_header_src(deq_src), .io_deq_bits_header_dst(deq_dst),
    .io_deq_bits_payload_manager_xact_id(deq_x),
    .io_count(count), .io_drop(drop)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  function automatic row_t mk(input logic ev, input int d, input int x, input logic dr,
                              input logic rdy, input logic vld, input int ed, input int ex,
                              input int cnt, input logic dp);
    row_t r;
    r.ev = ev; r.dst = 2'(d); r.x = 2'(x); r.dr = dr;
    r.rdy = rdy; r.vld = vld; r.edst = 2'(ed); r.ex = 2'(ex); r.cnt = 2'(cnt); r.drop = dp;
    return r;
  endfunction
  task automatic apply(input row_t r, input string tag);
    @(negedge clk);
    enq_valid = r.ev; enq_dst = r.dst; enq_x = r.x; deq_ready = r.dr;
    #1;
    chk({tag, ".ready"}, enq_ready, r.rdy);
    chk({tag, ".valid"}, deq_valid, r.vld);
    chk({tag, ".count"}, count, r.cnt);
    chk({tag, ".drop"}, drop, r.drop);
    chk({tag, ".src"}, deq_src, SRC_ID);
    if (r.vld) begin
      chk({tag, ".dst"}, deq_dst, r.edst);
      chk({tag, ".xact"}, deq_x, r.ex);
    end
  endtask
  task automatic chk_empty(input string tag);
    chk({tag, ".ready"}, enq_ready, 1);
    chk({tag, ".valid"}, deq_valid, 0);
    chk({tag, ".count"}, count, 0);
    chk({tag, ".drop"}, drop, 0);
  endtask
  initial begin
    row_t tbl[20];
    logic [3:0] mq[$];
    logic mdrop;
    tbl[0]  = mk(1, 2, 1, 1,  1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1,  1, 1, 2, 1, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 1, 0,  1, 1, 0, 0, 1, 0);
    tbl[5]  = mk(1, 2, 3, 0,  0, 1, 0, 0, 2, 0);
    tbl[6]  = mk(1, 2, 3, 0,  0, 1, 0, 0, 2, 0);
    tbl[7]  = mk(1, 2, 3, 1,  0, 1, 0, 0, 2, 0);
    tbl[8]  = mk(1, 2, 3, 1,  1, 1, 1, 1, 1, 0);
    tbl[9]  = mk(0, 0, 0, 1,  1, 1, 2, 3, 1, 0);
    tbl[10] = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 3, 2, 0,  1, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 3, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 1, 2, 0,  1, 0, 0, 0, 0, 1);
    tbl[16] = mk(1, 3, 1, 0,  1, 1, 1, 2, 1, 0);
    tbl[17] = mk(1, 3, 1, 0,  1, 1, 1, 2, 1, 1);
    tbl[18] = mk(0, 0, 0, 1,  1, 1, 1, 2, 1, 1);
    tbl[19] = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    #2;
    chk_empty("in_reset");
    @(negedge clk);
    reset = 1'b1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    // two entries stored, then reset asserted between clock edges
    apply(mk(1, 0, 1, 0,  1, 0, 0, 0, 0, 0), "rst_a");
    apply(mk(1, 1, 2, 0,  1, 1, 0, 1, 1, 0), "rst_b");
    apply(mk(0, 0, 0, 0,  0, 1, 0, 1, 2, 0), "rst_full");
    #2;
    reset = 1'b0;
    #1;
    chk_empty("rst_async");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_empty("rst_release");
    apply(mk(1, 2, 0, 1,  1, 0, 0, 0, 0, 0), "post_a");
    apply(mk(0, 0, 0, 1,  1, 1, 2, 0, 1, 0), "post_b");
    apply(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0), "post_c");
    mdrop = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      row_t r;
      r.ev = (i < 60) ? 1'b1 : 1'($urandom);
      r.dst = (i < 60) ? 2'($urandom_range(0, NUM_DST - 1)) : 2'($urandom);
      r.x = 2'($urandom);
      r.dr = (i < 60) ? 1'(i % 2) : 1'($urandom);
      r.rdy = mq.size() != DEPTH;
      r.vld = mq.size() != 0;
      r.edst = r.vld ? mq[0][3:2] : 2'd0;
      r.ex = r.vld ? mq[0][1:0] : 2'd0;
      r.cnt = 2'(mq.size());
      r.drop = mdrop;
      apply(r, $sformatf("rnd%0d", i));
      mdrop = r.ev && r.rdy && int'(r.dst) >= NUM_DST;
      if (r.vld && r.dr) void'(mq.pop_front());
      if (r.ev && r.rdy && int'(r.dst) < NUM_DST) mq.push_back({r.dst, r.x});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
